mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port program/data memory between two requesters: port 0 is the controller's instruction-fetch path (read-only) and port 1 is the program loader/debug path (read/write).
- Sequences each access as ISSUE, then a fixed-latency WAIT, then an ACK pulse.
- Arbitrates round-robin, with an optional bounded burst lock for the loader.
- Sits between the controller/loader and the memory macro in the SoC top level.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MEM_LAT, 1, memory read latency in cycles; legal range 1..15.
- LOCK_MAX, 4, maximum consecutive locked grants to port 1 while port 0 is requesting.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- CLB  in  1  asynchronous active-low reset.
- Req0  in  1  fetch request; held high until Ack0.
- Addr0  in  AW  fetch address.
- Req1  in  1  loader request; held high until Ack1.
- Addr1  in  AW  loader address.
- We1  in  1  loader write enable (1=write, 0=read).
- WData1  in  DW  loader write data.
- Lock1  in  1  loader burst-lock request.
- Gnt  out  2  one-hot owner of the current transaction.
- Ack  out  2  one-cycle completion pulse per port.
- RData  out  DW  registered read data; valid while Ack is high.
- Busy  out  1  high whenever state != IDLE.
- MemEn  out  1  memory access strobe.
- MemWe  out  1  memory write strobe.
- MemAddr  out  AW  memory address.
- MemWData  out  DW  memory write data.
- MemRData  in  DW  memory read data; valid MEM_LAT cycles after the MemEn cycle.

Behaviour:
- Reset (CLB low, asynchronous): state=IDLE.
  - All outputs 0: Gnt, Ack, RData, Busy, MemEn, MemWe, MemAddr, MemWData.
  - Internal Last=1, lock counter=0, latency counter=0.
  - Reset mid-transaction aborts the access immediately: MemEn drops without waiting for a clock; no Ack is issued.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs are registered except Busy, which decodes the state.
- IDLE, selecting the winner w:
  - Only Req0 high: w=0.
  - Only Req1 high: w=1.
  - Both high: w = the port other than Last. Exception: w=1 if Lock1=1, Last=1 and lock counter < LOCK_MAX.
  - Neither high: stay in IDLE.
- On grant, at the edge leaving IDLE:
  - Capture address, We (forced 0 for port 0) and WData into holding registers.
  - Set Gnt[w], Last=w; go to ISSUE.
  - Requester inputs are ignored from the cycle after capture until the next IDLE.
- Lock counter:
  - Increments when port 1 wins a both-requesting tie via the lock rule.
  - Clears when port 0 is granted or when Lock1=0 at grant.
  - Once it reaches LOCK_MAX, a pending Req0 wins the next tie.
- ISSUE (exactly 1 cycle): MemEn=1, MemWe=captured We, MemAddr/MemWData=captured values; load latency counter = MEM_LAT.
- WAIT (exactly MEM_LAT cycles):
  - MemEn=0 and MemWe=0; MemAddr holds its value.
  - Counter decrements each cycle.
  - At the edge ending the last WAIT cycle, reads register MemRData into RData; writes leave RData unchanged. Then go to DONE.
- DONE (1 cycle): Ack[w]=1, Gnt[w] still 1. At the following edge, Gnt and Ack clear and state returns to IDLE.
- Latency: with request first seen in IDLE cycle 0, ISSUE is cycle 1 and Ack is cycle 2+MEM_LAT. Back-to-back transactions take 3+MEM_LAT cycles each (one IDLE cycle between them).
- Gnt is one-hot or zero at all times. At most one Ack bit is ever high, and only in DONE.
- Requester drops Req before Ack: the transaction still completes and Ack still pulses (no abort, no retry).
- A request arriving during a transaction waits; it is evaluated in the next IDLE cycle.
- MEM_LAT outside 1..15 is a parameter error and must be flagged by elaboration assertion.

Test Plan:
- Reset with Req0=1, Addr0=0x10, MEM_LAT=1, memory returning 0xA5 at 0x10 -> MemEn in cycle 1 only; Ack0 and RData=0xA5 in cycle 3; Gnt=01 in cycles 1..3.
- Req0 and Req1 both held from reset with Lock1=0 -> grants alternate 0,1,0,1; first Ack0 in cycle 3, first Ack1 in cycle 7.
- Req1 write with We1=1, Addr1=0x20, WData1=0x3C -> MemWe=1 with MemAddr=0x20 and MemWData=0x3C in the ISSUE cycle; Ack1 pulses; RData keeps its prior value; a following port-0 read of 0x20 returns 0x3C.
- Lock1=1 with both ports requesting continuously, LOCK_MAX=4 -> after the first port-1 grant, four more locked port-1 grants occur, then port 0 is granted.
- MEM_LAT=3, Req0 high in cycle 0 -> Ack0 in cycle 5. Second run: assert CLB low in cycle 3 -> MemEn, Gnt and Busy go to 0 without waiting for a clock, no Ack, and the next request after release sees full latency.
- Req1 read issued, Req1 deasserted in cycle 2, MEM_LAT=2 -> Ack1 still pulses in cycle 4; no second grant follows.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-port arbiter for a single-port memory. Port 0 is the
//               read-only instruction fetch path, port 1 the loader/debug
//               read/write path. Each access runs ISSUE -> WAIT(MEM_LAT) ->
//               DONE(Ack). Round-robin arbitration, with a bounded burst lock
//               that lets the loader keep the memory while fetch is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MEM_LAT  = 1,
    parameter int LOCK_MAX = 4
) (
    input  logic          CLK,
    input  logic          CLB,
    input  logic          Req0,
    input  logic [AW-1:0] Addr0,
    input  logic          Req1,
    input  logic [AW-1:0] Addr1,
    input  logic          We1,
    input  logic [DW-1:0] WData1,
    input  logic          Lock1,
    output logic [1:0]    Gnt,
    output logic [1:0]    Ack,
    output logic [DW-1:0] RData,
    output logic          Busy,
    output logic          MemEn,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData
);

    localparam int               c_LCW      = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
    localparam logic [c_LCW-1:0] c_LOCK_MAX = c_LCW'(LOCK_MAX);
    localparam logic [3:0]       c_MEM_LAT  = 4'(MEM_LAT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // The latency counter is 4 bits wide, so only 1..15 can be represented.
    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_badMemLat
            $error("mem_port_arbiter: MEM_LAT=%0d outside legal range 1..15", MEM_LAT);
        end
    endgenerate

    logic [1:0]       r_state;
    logic             r_last;
    logic [c_LCW-1:0] r_lockCnt;
    logic [3:0]       r_latCnt;
    logic             r_we;
    logic [1:0]       r_gnt;
    logic [1:0]       r_ack;
    logic [DW-1:0]    r_rdata;
    logic             r_memEn;
    logic             r_memWe;
    logic [AW-1:0]    r_memAddr;
    logic [DW-1:0]    r_memWData;

    logic w_any;
    logic w_win;
    logic w_lockWin;

    assign w_any = Req0 | Req1;

    // Winner selection for the IDLE cycle: a lone requester wins, a tie goes
    // to the port that did not own the last access unless the loader lock holds.
    always_comb begin
        w_win     = 1'b0;
        w_lockWin = 1'b0;
        if (Req0 && Req1) begin
            if (Lock1 && r_last && (r_lockCnt < c_LOCK_MAX)) begin
                w_win     = 1'b1;
                w_lockWin = 1'b1;
            end else begin
                w_win = ~r_last;
            end
        end else begin
            w_win = Req1;
        end
    end

    // Transaction sequencer; the memory interface signals double as the
    // holding registers for the captured request.
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            r_state    <= c_IDLE;
            r_last     <= 1'b1;
            r_lockCnt  <= '0;
            r_latCnt   <= '0;
            r_we       <= 1'b0;
            r_gnt      <= 2'b00;
            r_ack      <= 2'b00;
            r_rdata    <= '0;
            r_memEn    <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWData <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_state    <= c_ISSUE;
                        r_gnt      <= w_win ? 2'b10 : 2'b01;
                        r_last     <= w_win;
                        r_we       <= w_win & We1;
                        r_memEn    <= 1'b1;
                        r_memWe    <= w_win & We1;
                        r_memAddr  <= w_win ? Addr1 : Addr0;
                        r_memWData <= w_win ? WData1 : '0;
                        if (w_lockWin) begin
                            r_lockCnt <= r_lockCnt + 1'b1;
                        end else if (!w_win || !Lock1) begin
                            r_lockCnt <= '0;
                        end
                    end
                end
                c_ISSUE: begin
                    r_memEn  <= 1'b0;
                    r_memWe  <= 1'b0;
                    r_latCnt <= c_MEM_LAT;
                    r_state  <= c_WAIT;
                end
                c_WAIT: begin
                    r_latCnt <= r_latCnt - 1'b1;
                    if (r_latCnt == 4'd1) begin
                        if (!r_we) begin
                            r_rdata <= MemRData;
                        end
                        r_ack   <= r_gnt;
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_ack   <= 2'b00;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign Gnt      = r_gnt;
    assign Ack      = r_ack;
    assign RData    = r_rdata;
    assign Busy     = (r_state != c_IDLE);
    assign MemEn    = r_memEn;
    assign MemWe    = r_memWe;
    assign MemAddr  = r_memAddr;
    assign MemWData = r_memWData;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a transaction-
//               level arbitration/memory model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_LAT  = 3;
    localparam int c_LOCK = 4;
    localparam int c_TXN  = 3 + c_LAT;

    logic       CLK;
    logic       CLB;
    logic       Req0;
    logic [7:0] Addr0;
    logic       Req1;
    logic [7:0] Addr1;
    logic       We1;
    logic [7:0] WData1;
    logic       Lock1;
    logic [1:0] Gnt;
    logic [1:0] Ack;
    logic [7:0] RData;
    logic       Busy;
    logic       MemEn;
    logic       MemWe;
    logic [7:0] MemAddr;
    logic [7:0] MemWData;
    logic [7:0] MemRData;

    int nChecks;
    int nFails;

    // Reference model state
    bit         mLast;
    int         mLock;
    logic [7:0] mRData;
    logic [7:0] refMem [256];

    // Memory macro stand-in
    logic [7:0] memArr [256];
    logic [7:0] rdAddr;

    mem_port_arbiter #(
        .AW(8), .DW(8), .MEM_LAT(c_LAT), .LOCK_MAX(c_LOCK)
    ) dut (
        .CLK(CLK), .CLB(CLB),
        .Req0(Req0), .Addr0(Addr0),
        .Req1(Req1), .Addr1(Addr1), .We1(We1), .WData1(WData1), .Lock1(Lock1),
        .Gnt(Gnt), .Ack(Ack), .RData(RData), .Busy(Busy),
        .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] initVal(input int i);
        if (i == 16) return 8'hA5;
        return 8'(i) ^ 8'h5A;
    endfunction

    function automatic logic [1:0] oh(input bit w);
        return w ? 2'b10 : 2'b01;
    endfunction

    // Memory: writes land on the MemEn edge, reads present data from then on.
    always @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            for (int i = 0; i < 256; i++) memArr[i] <= initVal(i);
            rdAddr <= 8'h00;
        end else if (MemEn) begin
            if (MemWe) memArr[MemAddr] <= MemWData;
            else       rdAddr <= MemAddr;
        end
    end
    assign MemRData = memArr[rdAddr];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) refMem[i] = initVal(i);
        mLast  = 1'b1;
        mLock  = 0;
        mRData = 8'h00;
    endtask

    // Arbitration rules at transaction level.
    task automatic modelPick(input bit r0, input bit r1, input bit l1, output bit w);
        bit locked;
        locked = 1'b0;
        if (r0 && r1) begin
            if (l1 && mLast && mLock < c_LOCK) begin
                w = 1'b1;
                locked = 1'b1;
            end else begin
                w = !mLast;
            end
        end else begin
            w = r1;
        end
        if (locked)          mLock = mLock + 1;
        else if (!w || !l1)  mLock = 0;
        mLast = w;
    endtask

    task automatic clear_inputs();
        Req0 = 0; Req1 = 0; We1 = 0; Lock1 = 0;
        Addr0 = 8'h00; Addr1 = 8'h00; WData1 = 8'h00;
    endtask

    task automatic do_reset();
        CLB = 1'b0;
        clear_inputs();
        model_reset();
        tick();
        tick();
        CLB = 1'b1;
    endtask

    task automatic test_reset();
        bit w;
        CLB = 1'b0;
        clear_inputs();
        Req0 = 1; Addr0 = 8'h10;
        model_reset();
        tick();
        #2;
        nChecks++;
        if ({Gnt, Ack, RData, Busy, MemEn, MemWe, MemAddr, MemWData} !== '0) begin
            nFails++;
            $display("FAIL reset_outputs: got %h want 0",
                     {Gnt, Ack, RData, Busy, MemEn, MemWe, MemAddr, MemWData});
        end
        tick();
        CLB = 1'b1;
        nChecks++;
        if ({Busy, MemEn} !== 2'b00) begin
            nFails++;
            $display("FAIL reset_cycle0: Busy,MemEn got %b want 00", {Busy, MemEn});
        end
        modelPick(1, 0, 0, w);
        tick();
        nChecks++;
        if ({MemEn, Gnt, MemAddr} !== {1'b1, oh(w), 8'h10}) begin
            nFails++;
            $display("FAIL reset_issue: MemEn,Gnt,MemAddr got %b %b %h want 1 %b 10",
                     MemEn, Gnt, MemAddr, oh(w));
        end
        for (int c = 2; c <= 1 + c_LAT; c++) begin
            tick();
            nChecks++;
            if ({MemEn, Gnt, Ack} !== {1'b0, oh(w), 2'b00}) begin
                nFails++;
                $display("FAIL reset_wait c%0d: MemEn,Gnt,Ack got %b %b %b want 0 %b 00",
                         c, MemEn, Gnt, Ack, oh(w));
            end
        end
        tick();
        mRData = refMem[8'h10];
        nChecks++;
        if ({Ack, Gnt, RData} !== {oh(w), oh(w), mRData}) begin
            nFails++;
            $display("FAIL reset_done: Ack,Gnt,RData got %b %b %h want %b %b %h",
                     Ack, Gnt, RData, oh(w), oh(w), mRData);
        end
        Req0 = 0;
        tick();
        nChecks++;
        if ({Gnt, Ack, Busy} !== 5'b0) begin
            nFails++;
            $display("FAIL reset_idle: Gnt,Ack,Busy got %b %b %b want 0", Gnt, Ack, Busy);
        end
    endtask

    task automatic test_round_robin();
        int ackCyc[$];
        bit ackPort[$];
        bit w;
        do_reset();
        Req0 = 1; Req1 = 1; Addr0 = 8'h10; Addr1 = 8'h33; Lock1 = 0; We1 = 0;
        for (int cyc = 0; cyc < 4 * c_TXN; cyc++) begin
            if (Ack != 2'b00) begin
                ackCyc.push_back(cyc);
                ackPort.push_back(Ack[1]);
            end
            nChecks++;
            if ($countones(Gnt) > 1) begin
                nFails++;
                $display("FAIL rr_onehot cyc%0d: Gnt got %b want one-hot or zero", cyc, Gnt);
            end
            tick();
        end
        Req0 = 0; Req1 = 0;
        nChecks++;
        if (ackCyc.size() != 4) begin
            nFails++;
            $display("FAIL rr_ack_count: got %0d want 4", ackCyc.size());
        end
        for (int k = 0; k < 4; k++) begin
            modelPick(1, 1, 0, w);
            mRData = refMem[w ? 8'h33 : 8'h10];
            if (k < ackCyc.size()) begin
                nChecks++;
                if (ackPort[k] != w || ackCyc[k] != k * c_TXN + 2 + c_LAT) begin
                    nFails++;
                    $display("FAIL rr_ack%0d: port %0d cycle %0d want port %0d cycle %0d",
                             k, ackPort[k], ackCyc[k], w, k * c_TXN + 2 + c_LAT);
                end
            end
        end
    endtask

    task automatic test_write_readback();
        bit w;
        logic [7:0] prev;
        prev = mRData;
        Req1 = 1; We1 = 1; Addr1 = 8'h20; WData1 = 8'h3C; Lock1 = 0;
        modelPick(0, 1, 0, w);
        refMem[8'h20] = 8'h3C;
        tick();
        nChecks++;
        if ({MemEn, MemWe, MemAddr, MemWData, Gnt} !== {2'b11, 8'h20, 8'h3C, oh(w)}) begin
            nFails++;
            $display("FAIL wr_issue: En,We,Addr,WData,Gnt got %b%b %h %h %b want 11 20 3c %b",
                     MemEn, MemWe, MemAddr, MemWData, Gnt, oh(w));
        end
        repeat (c_LAT + 1) tick();
        nChecks++;
        if ({Ack, RData} !== {oh(w), prev}) begin
            nFails++;
            $display("FAIL wr_done: Ack,RData got %b %h want %b %h", Ack, RData, oh(w), prev);
        end
        Req1 = 0; We1 = 0;
        tick();
        Req0 = 1; Addr0 = 8'h20;
        modelPick(1, 0, 0, w);
        repeat (c_LAT + 2) tick();
        mRData = refMem[8'h20];
        nChecks++;
        if ({Ack, RData} !== {oh(w), mRData}) begin
            nFails++;
            $display("FAIL wr_readback: Ack,RData got %b %h want %b %h", Ack, RData, oh(w), mRData);
        end
        Req0 = 0;
        tick();
    endtask

    task automatic test_lock();
        bit w;
        bit seq [7];
        seq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        Addr0 = 8'h11; Addr1 = 8'h22; Lock1 = 1; We1 = 0;
        for (int k = 0; k < 7; k++) begin
            Req0 = 1;
            Req1 = (k != 0);
            modelPick(1, k != 0, 1, w);
            tick();
            nChecks++;
            if (Gnt !== oh(seq[k])) begin
                nFails++;
                $display("FAIL lock_gnt%0d: got %b want %b", k, Gnt, oh(seq[k]));
            end
            repeat (c_LAT + 1) tick();
            mRData = refMem[w ? 8'h22 : 8'h11];
            nChecks++;
            if (Ack !== oh(seq[k])) begin
                nFails++;
                $display("FAIL lock_ack%0d: got %b want %b", k, Ack, oh(seq[k]));
            end
            tick();
        end
        Req0 = 0; Req1 = 0; Lock1 = 0;
    endtask

    task automatic test_latency_async_reset();
        int ackAt;
        do_reset();
        Req0 = 1; Addr0 = 8'h44;
        ackAt = -1;
        for (int c = 0; c < 16 && ackAt < 0; c++) begin
            if (Ack == 2'b01) begin
                ackAt = c;
                Req0 = 0;
            end else begin
                tick();
            end
        end
        nChecks++;
        if (ackAt != 2 + c_LAT) begin
            nFails++;
            $display("FAIL lat_ack: cycle got %0d want %0d", ackAt, 2 + c_LAT);
        end
        tick();

        // Reset in the ISSUE cycle: MemEn must fall without a clock edge.
        do_reset();
        Req0 = 1; Addr0 = 8'h44;
        tick();
        #2 CLB = 1'b0;
        #1;
        nChecks++;
        if ({MemEn, Gnt, Busy} !== 4'b0) begin
            nFails++;
            $display("FAIL areset_issue: MemEn,Gnt,Busy got %b %b %b want 0", MemEn, Gnt, Busy);
        end
        tick();
        nChecks++;
        if (Ack !== 2'b00) begin
            nFails++;
            $display("FAIL areset_noack1: Ack got %b want 00", Ack);
        end
        CLB = 1'b1;
        model_reset();

        // Reset in cycle 3 (inside WAIT).
        tick(); tick(); tick();
        #2 CLB = 1'b0;
        #1;
        nChecks++;
        if ({MemEn, Gnt, Busy, MemAddr} !== 12'b0) begin
            nFails++;
            $display("FAIL areset_wait: MemEn,Gnt,Busy,MemAddr got %b %b %b %h want 0",
                     MemEn, Gnt, Busy, MemAddr);
        end
        tick();
        nChecks++;
        if (Ack !== 2'b00) begin
            nFails++;
            $display("FAIL areset_noack2: Ack got %b want 00", Ack);
        end
        CLB = 1'b1;
        model_reset();
        mLast = 1'b0;
        ackAt = -1;
        for (int c = 0; c < 16 && ackAt < 0; c++) begin
            if (Ack == 2'b01) begin
                ackAt = c;
                Req0 = 0;
            end else begin
                tick();
            end
        end
        mRData = refMem[8'h44];
        nChecks++;
        if (ackAt != 2 + c_LAT || RData !== mRData) begin
            nFails++;
            $display("FAIL areset_relat: cycle %0d RData %h want cycle %0d RData %h",
                     ackAt, RData, 2 + c_LAT, mRData);
        end
        tick();
    endtask

    task automatic test_req_drop();
        bit w;
        Req1 = 1; We1 = 0; Addr1 = 8'h55; Lock1 = 0;
        modelPick(0, 1, 0, w);
        tick();
        tick();
        Req1 = 0;
        repeat (c_LAT) tick();
        mRData = refMem[8'h55];
        nChecks++;
        if ({Ack, RData} !== {oh(w), mRData}) begin
            nFails++;
            $display("FAIL drop_ack: Ack,RData got %b %h want %b %h", Ack, RData, oh(w), mRData);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            nChecks++;
            if ({Gnt, Ack, Busy} !== 5'b0) begin
                nFails++;
                $display("FAIL drop_idle%0d: Gnt,Ack,Busy got %b %b %b want 0", c, Gnt, Ack, Busy);
            end
        end
    endtask

    task automatic test_random();
        bit r0, r1, l1, we, w, eWe;
        logic [7:0] a0, a1, wd, eAddr, eRd;
        for (int it = 0; it < 60; it++) begin
            r0 = ($urandom % 3) != 0;
            r1 = ($urandom % 3) != 0;
            l1 = 1'($urandom);
            we = 1'($urandom);
            a0 = 8'h20 + 8'($urandom % 8);
            a1 = 8'h20 + 8'($urandom % 8);
            wd = 8'($urandom);
            Req0 = r0; Req1 = r1; Lock1 = l1; We1 = we;
            Addr0 = a0; Addr1 = a1; WData1 = wd;
            if (!r0 && !r1) begin
                tick();
                nChecks++;
                if ({Busy, Gnt} !== 3'b0) begin
                    nFails++;
                    $display("FAIL rnd_idle%0d: Busy,Gnt got %b %b want 0", it, Busy, Gnt);
                end
                continue;
            end
            modelPick(r0, r1, l1, w);
            eAddr = w ? a1 : a0;
            eWe   = w & we;
            if (eWe) refMem[eAddr] = wd;
            tick();
            nChecks++;
            if ({Gnt, MemEn, MemWe, MemAddr} !== {oh(w), 1'b1, eWe, eAddr} ||
                (eWe && MemWData !== wd)) begin
                nFails++;
                $display("FAIL rnd_issue%0d: Gnt %b En %b We %b Addr %h WData %h want %b 1 %b %h %h",
                         it, Gnt, MemEn, MemWe, MemAddr, MemWData, oh(w), eWe, eAddr, wd);
            end
            for (int c = 0; c < c_LAT; c++) begin
                Req0 = 1'($urandom); Req1 = 1'($urandom); Lock1 = 1'($urandom);
                We1 = 1'($urandom); Addr0 = 8'($urandom); Addr1 = 8'($urandom);
                WData1 = 8'($urandom);
                tick();
                nChecks++;
                if ({MemEn, MemWe, Ack, Busy, Gnt, MemAddr} !== {4'b0000, 1'b1, oh(w), eAddr}) begin
                    nFails++;
                    $display("FAIL rnd_wait%0d: En %b We %b Ack %b Busy %b Gnt %b Addr %h want 0 0 00 1 %b %h",
                             it, MemEn, MemWe, Ack, Busy, Gnt, MemAddr, oh(w), eAddr);
                end
            end
            tick();
            eRd = eWe ? mRData : refMem[eAddr];
            mRData = eRd;
            nChecks++;
            if ({Ack, Gnt, RData} !== {oh(w), oh(w), eRd}) begin
                nFails++;
                $display("FAIL rnd_done%0d: Ack %b Gnt %b RData %h want %b %b %h",
                         it, Ack, Gnt, RData, oh(w), oh(w), eRd);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        CLB     = 1'b0;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_write_readback();
        test_lock();
        test_latency_async_reset();
        test_req_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
